// File: rtl/tv_stream_checker.sv
// In-order result checker: buffers expected words and compares each DUT output beat against the oldest.
// Optional first-mismatch capture ports are enabled by defining CHK_FIRST_ERR_EN.
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | accepting expected words and comparing DUT beats
// DRAIN | last expected word accepted; comparing until FIFO empty or timeout
// DONE  | verdict held until reset
module tv_stream_checker #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_exp_valid,
    output logic              o_exp_ready,
    input  logic [DATA_W-1:0] i_exp_data,
    input  logic              i_exp_last,
    input  logic              i_out_valid,
    input  logic [DATA_W-1:0] i_out_data,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic              o_underflow,
    output logic [CNT_W-1:0]  o_cmp_count,
    output logic [CNT_W-1:0]  o_err_count
`ifdef CHK_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0]  o_first_err_idx,
    output logic [DATA_W-1:0] o_first_err_exp,
    output logic [DATA_W-1:0] o_first_err_got
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FILL_W-1:0] fill;
    logic [TO_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]  cmp_count, err_count;
    logic              timeout_flag, underflow_flag;

    logic full, empty, active, push, pop, underflow_beat, mismatch, timeout_hit;

    // Full/empty come straight from the registered fill level, so a pop never frees a slot in the same cycle.
    assign full           = (fill == FILL_W'(FIFO_DEPTH));
    assign empty          = (fill == '0);
    assign active         = (state == RUN) || (state == DRAIN);
    assign o_exp_ready    = (state == RUN) && !full;
    assign push           = i_exp_valid && o_exp_ready;
    assign pop            = active && i_out_valid && !empty;
    assign underflow_beat = active && i_out_valid && empty;
    assign mismatch       = pop && (i_out_data != mem[rd_ptr]);

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:  if (i_start) state_next = RUN;
            RUN:   if (push && i_exp_last) state_next = DRAIN;
            DRAIN: begin
                if (fill == FILL_W'(pop)) begin
                    state_next = DONE;
                end else if (!pop && (idle_cnt == TO_W'(TIMEOUT_CYC - 1))) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE:  state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_exp_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill           <= '0;
            idle_cnt       <= '0;
            cmp_count      <= '0;
            err_count      <= '0;
            timeout_flag   <= 1'b0;
            underflow_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
            if (pop || (state == RUN && state_next == DRAIN)) begin
                idle_cnt <= '0;
            end else if (state == DRAIN) begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end
            if (pop && cmp_count != CNT_MAX) cmp_count <= cmp_count + CNT_W'(1);
            if ((mismatch || underflow_beat) && err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (underflow_beat) underflow_flag <= 1'b1;
            if (timeout_hit)    timeout_flag   <= 1'b1;
        end
    end

`ifdef CHK_FIRST_ERR_EN
    logic first_seen;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            first_seen      <= 1'b0;
            o_first_err_idx <= '0;
            o_first_err_exp <= '0;
            o_first_err_got <= '0;
        end else if (mismatch && !first_seen) begin
            first_seen      <= 1'b1;
            o_first_err_idx <= cmp_count;
            o_first_err_exp <= mem[rd_ptr];
            o_first_err_got <= i_out_data;
        end
    end
`endif

    assign o_done      = (state == DONE);
    assign o_pass      = (state == DONE) && !timeout_flag && !underflow_flag && (err_count == '0);
    assign o_timeout   = timeout_flag;
    assign o_underflow = underflow_flag;
    assign o_cmp_count = cmp_count;
    assign o_err_count = err_count;

endmodule
